// File: rtl/amo_exec_unit_pkg.sv
// amo_exec_unit_pkg: memory-op command codes, size codes, FSM states and decode helpers
package amo_exec_unit_pkg;
  localparam logic [4:0] M_XRD       = 5'b00000;
  localparam logic [4:0] M_XWR       = 5'b00001;
  localparam logic [4:0] M_PFR       = 5'b00010;
  localparam logic [4:0] M_PFW       = 5'b00011;
  localparam logic [4:0] M_XA_SWAP   = 5'b00100;
  localparam logic [4:0] M_FLUSH_ALL = 5'b00101;
  localparam logic [4:0] M_XLR       = 5'b00110;
  localparam logic [4:0] M_XSC       = 5'b00111;
  localparam logic [4:0] M_XA_ADD    = 5'b01000;
  localparam logic [4:0] M_XA_XOR    = 5'b01001;
  localparam logic [4:0] M_XA_OR     = 5'b01010;
  localparam logic [4:0] M_XA_AND    = 5'b01011;
  localparam logic [4:0] M_XA_MIN    = 5'b01100;
  localparam logic [4:0] M_XA_MAX    = 5'b01101;
  localparam logic [4:0] M_XA_MINU   = 5'b01110;
  localparam logic [4:0] M_XA_MAXU   = 5'b01111;

  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} amo_state_e;

  // ADD..MAXU occupy 01xxx; SWAP sits apart from them
  function automatic logic isAMO(input logic [4:0] cmd);
    return cmd == M_XA_SWAP || cmd[4:3] == 2'b01;
  endfunction

  function automatic logic isLR(input logic [4:0] cmd);
    return cmd == M_XLR;
  endfunction

  function automatic logic isSC(input logic [4:0] cmd);
    return cmd == M_XSC;
  endfunction
endpackage

// File: rtl/amo_alu.sv
// amo_alu: combinational AMO datapath for 32/64-bit operands
//   cmd  : M_* opcode          size : SZ_W / SZ_D
//   lane : addr[2], selects the 32-bit word of a for SZ_W
//   a    : old memory doubleword   b : request operand, right-justified
//   res  : value to write (32-bit results replicated to both lanes)
//   old  : old value of the addressed word, sign-extended for SZ_W
module amo_alu
  import amo_exec_unit_pkg::*;
(
  input  logic [4:0]  cmd,
  input  logic [1:0]  size,
  input  logic        lane,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] res,
  output logic [63:0] old
);
  logic        w;
  logic        lt;
  logic [31:0] a32;
  logic [63:0] ea;
  logic [63:0] eb;
  logic [63:0] r;

  // 32-bit operands are sign-extended to 64 bits: the signed order is kept, and
  // the unsigned 64-bit order of two sign-extended words equals their unsigned
  // 32-bit order, so one 64-bit compare and adder serve both widths
  always_comb begin
    w   = size == SZ_W;
    a32 = lane ? a[63:32] : a[31:0];
    ea  = w ? {{32{a32[31]}}, a32} : a;
    eb  = w ? {{32{b[31]}}, b[31:0]} : b;
    lt  = (cmd == M_XA_MIN || cmd == M_XA_MAX) ? $signed(ea) < $signed(eb) : ea < eb;
    r   = cmd == M_XA_ADD ? ea + eb :
          cmd == M_XA_XOR ? ea ^ eb :
          cmd == M_XA_OR  ? ea | eb :
          cmd == M_XA_AND ? ea & eb :
          (cmd == M_XA_MIN || cmd == M_XA_MINU) ? (lt ? ea : eb) :
          (cmd == M_XA_MAX || cmd == M_XA_MAXU) ? (lt ? eb : ea) : eb;
    res = w ? {2{r[31:0]}} : r;
    old = ea;
  end
endmodule

// File: rtl/amo_exec_unit.sv
// amo_exec_unit: executes LR/SC/AMO commands as read-modify-write sequences on the data array
//   req_*      : command in (accepted only when idle)
//   resp_*     : old value / SC status / error out, held until resp_ready
//   mem_req_*  : data-array access, 8-byte aligned, lane-replicated data with byte mask
//   mem_resp_* : read data, one pulse per read
//   probe_*    : external invalidate/probe, kills a matching reservation
module amo_exec_unit
  import amo_exec_unit_pkg::*;
#(
  parameter int ADDR_W        = 40,
  parameter int TAG_W         = 6,
  parameter int RSV_GRAN_LOG2 = 6,
  parameter int LR_TIMEOUT    = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [63:0]       req_data,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [63:0]       mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_data,
  input  logic              probe_valid,
  input  logic [ADDR_W-1:0] probe_addr
);
  localparam int CNT_W = $clog2(LR_TIMEOUT + 1);
  localparam int GR_W  = ADDR_W - RSV_GRAN_LOG2;

  amo_state_e        state;
  amo_state_e        state_n;
  logic [4:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [63:0]       data;
  logic              rsv_valid;
  logic [GR_W-1:0]   rsv_gran;
  logic [CNT_W-1:0]  cnt;
  logic [63:0]       alu_res;
  logic [63:0]       alu_old;
  logic              accept;
  logic              legal;
  logic              sc_hit;
  logic              lr_set;
  logic              rsv_clr;
  logic [GR_W-1:0]   req_gran;
  logic [GR_W-1:0]   cur_gran;
  logic [GR_W-1:0]   probe_gran;
  logic              unused_ok;

  assign req_ready     = state == IDLE;
  assign resp_valid    = state == RESP;
  assign mem_req_valid = state == RD_REQ || state == WR_REQ;
  assign mem_req_we    = state == WR_REQ;
  assign mem_req_addr  = {addr[ADDR_W-1:3], 3'b000};
  assign req_gran      = req_addr[ADDR_W-1:RSV_GRAN_LOG2];
  assign cur_gran      = addr[ADDR_W-1:RSV_GRAN_LOG2];
  assign probe_gran    = probe_addr[ADDR_W-1:RSV_GRAN_LOG2];
  assign unused_ok     = ^{addr[1:0], probe_addr[RSV_GRAN_LOG2-1:0]};

  always_comb begin
    accept  = req_valid && req_ready;
    legal   = (isLR(req_cmd) || isSC(req_cmd) || isAMO(req_cmd)) &&
              (req_size == SZ_D ? req_addr[2:0] == 3'd0 : req_size == SZ_W && req_addr[1:0] == 2'd0);
    sc_hit  = rsv_valid && rsv_gran == req_gran;
    lr_set  = state == RD_WAIT && mem_resp_valid && isLR(cmd);
    // any single source is enough to kill the reservation; they may coincide
    rsv_clr = (probe_valid && probe_gran == rsv_gran) ||
              (accept && legal && isSC(req_cmd)) ||
              (state == WR_REQ && mem_req_ready && isAMO(cmd) && cur_gran == rsv_gran) ||
              cnt == CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = !legal ? RESP : isSC(req_cmd) ? (sc_hit ? WR_REQ : RESP) : RD_REQ;
      RD_REQ:  if (mem_req_ready) state_n = RD_WAIT;
      RD_WAIT: if (mem_resp_valid) state_n = isLR(cmd) ? RESP : WR_REQ;
      WR_REQ:  if (mem_req_ready) state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // SC write data and all masks are fixed at accept; AMO write data is
  // replaced by the ALU result when the old value arrives
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd           <= '0;
      addr          <= '0;
      size          <= '0;
      data          <= '0;
      resp_tag      <= '0;
      resp_err      <= 1'b0;
      resp_data     <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else if (accept) begin
      cmd           <= req_cmd;
      addr          <= req_addr;
      size          <= req_size;
      data          <= req_data;
      resp_tag      <= req_tag;
      resp_err      <= !legal;
      resp_data     <= (legal && isSC(req_cmd) && !sc_hit) ? 64'd1 : 64'd0;
      mem_req_wdata <= req_size == SZ_W ? {2{req_data[31:0]}} : req_data;
      mem_req_wmask <= req_size == SZ_W ? (req_addr[2] ? 8'hF0 : 8'h0F) : 8'hFF;
    end else if (state == RD_WAIT && mem_resp_valid) begin
      resp_data     <= alu_old;
      mem_req_wdata <= alu_res;
    end

  // a probe of the granule being reserved in the same cycle wins over the set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsv_valid <= 1'b0;
      rsv_gran  <= '0;
      cnt       <= '0;
    end else if (lr_set) begin
      rsv_valid <= !(probe_valid && probe_gran == cur_gran);
      rsv_gran  <= cur_gran;
      cnt       <= CNT_W'(LR_TIMEOUT);
    end else if (rsv_valid) begin
      rsv_valid <= !rsv_clr;
      cnt       <= cnt - CNT_W'(1);
    end

  amo_alu u_alu (
    .cmd  (cmd),
    .size (size),
    .lane (addr[2]),
    .a    (mem_resp_data),
    .b    (data),
    .res  (alu_res),
    .old  (alu_old)
  );
endmodule

// File: tb/tb_amo_exec_unit.sv
// tb_amo_exec_unit: scoreboard bench with a behavioural data-array model
module tb_amo_exec_unit;
  import amo_exec_unit_pkg::*;
  localparam int ADDR_W = 40;
  localparam int TAG_W  = 6;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [63:0]       req_data;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [63:0]       mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_data;
  logic              probe_valid;
  logic [ADDR_W-1:0] probe_addr;

  typedef struct packed {
    logic [63:0]      data;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t        sb[$];
  int          rx = 0;
  int          passed = 0;
  int          total = 0;
  logic [63:0] mem [logic [ADDR_W-1:0]];
  int          reads = 0;
  int          writes = 0;
  logic [63:0] last_wdata;
  logic [7:0]  last_wmask;
  int          rd_lat = 1;
  int          stall_w = 0;
  int          resp_hold = 0;
  int          probe_seq = 0;
  int          probe_kind = 0;
  logic [ADDR_W-1:0] probe_at = '0;
  logic [TAG_W-1:0]  tg = 6'd1;

  amo_exec_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_size(req_size), .req_data(req_data), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .probe_valid(probe_valid), .probe_addr(probe_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else passed++;
  endtask

  function automatic logic [ADDR_W-1:0] key(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:3], 3'b000};
  endfunction

  function automatic logic [63:0] mrd(input logic [ADDR_W-1:0] a);
    return mem.exists(key(a)) ? mem[key(a)] : 64'd0;
  endfunction

  function automatic logic [63:0] bmask(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  // data array: stalls each write for stall_w cycles, returns reads rd_lat cycles after the handshake
  initial begin
    int               rd_cnt;
    int               wcnt;
    logic [63:0]      rd_val;
    logic             m_stalled;
    logic [ADDR_W-1:0] sv_addr;
    logic [63:0]      sv_wdata;
    logic [8:0]       sv_ctl;
    int               probe_ack;
    rd_cnt = 0; wcnt = 0; rd_val = '0; m_stalled = 1'b0; probe_ack = 0;
    sv_addr = '0; sv_wdata = '0; sv_ctl = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
    probe_valid = 1'b0; probe_addr = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      probe_valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data = rd_val;
          if (probe_seq != probe_ack && probe_kind == 2) begin
            probe_valid = 1'b1; probe_addr = probe_at; probe_ack = probe_seq;
          end
        end
      end
      if (probe_seq != probe_ack && probe_kind == 1) begin
        probe_valid = 1'b1; probe_addr = probe_at; probe_ack = probe_seq;
      end
      if (m_stalled && rst_n) begin
        check("mreq_valid_hold", mem_req_valid, 1);
        check("mreq_addr_hold", mem_req_addr, sv_addr);
        check("mreq_wdata_hold", mem_req_wdata, sv_wdata);
        check("mreq_ctl_hold", {mem_req_we, mem_req_wmask}, sv_ctl);
      end
      mem_req_ready = !(mem_req_valid && mem_req_we && wcnt < stall_w);
      m_stalled = !mem_req_ready;
      if (m_stalled) begin
        wcnt++;
        sv_addr = mem_req_addr; sv_wdata = mem_req_wdata; sv_ctl = {mem_req_we, mem_req_wmask};
      end
      if (mem_req_valid && mem_req_ready && rst_n) begin
        if (mem_req_we) begin
          wcnt = 0;
          writes++;
          last_wdata = mem_req_wdata;
          last_wmask = mem_req_wmask;
          mem[key(mem_req_addr)] = (mrd(mem_req_addr) & ~bmask(mem_req_wmask)) |
                                   (mem_req_wdata & bmask(mem_req_wmask));
        end else begin
          reads++;
          rd_val = mrd(mem_req_addr);
          rd_cnt = rd_lat;
        end
      end
    end
  end

  // response side: holds resp_ready low resp_hold cycles per response, then scores it
  initial begin
    int               hcnt;
    logic             r_stalled;
    logic [63:0]      sv_data;
    logic [TAG_W:0]   sv_te;
    exp_t             e;
    hcnt = 0; r_stalled = 1'b0; sv_data = '0; sv_te = '0;
    resp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (r_stalled && rst_n) begin
        check("resp_valid_hold", resp_valid, 1);
        check("resp_data_hold", resp_data, sv_data);
        check("resp_tag_err_hold", {resp_tag, resp_err}, sv_te);
      end
      resp_ready = !(resp_valid && hcnt < resp_hold);
      r_stalled = !resp_ready;
      if (r_stalled) begin
        hcnt++;
        sv_data = resp_data; sv_te = {resp_tag, resp_err};
      end
      if (resp_valid && resp_ready && rst_n) begin
        hcnt = 0;
        if (rx < sb.size()) begin
          e = sb[rx];
          check("resp_data", resp_data, e.data);
          check("resp_err", resp_err, e.err);
          check("resp_tag", resp_tag, e.tag);
        end else check("resp_unexpected", 1, 0);
        rx++;
      end
    end
  end

  task automatic send(input logic [4:0] c, input logic [ADDR_W-1:0] a, input logic [1:0] s, input logic [63:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_cmd = c; req_addr = a; req_size = s; req_data = d; req_tag = tg;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    tg++;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rx != sb.size() && n < 300) begin @(negedge clk); n++; end
    check("resp_seen", rx == sb.size(), 1);
    @(negedge clk);
  endtask

  task automatic op(input logic [4:0] c, input logic [ADDR_W-1:0] a, input logic [1:0] s,
                    input logic [63:0] d, input logic [63:0] ed, input logic ee);
    sb.push_back('{data: ed, err: ee, tag: tg});
    send(c, a, s, d);
    wait_done();
  endtask

  initial begin
    int r0;
    int w0;
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_size = '0; req_data = '0; req_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[40'h1000] = 64'd5;
    op(M_XA_ADD, 40'h1000, SZ_D, 64'd3, 64'd5, 1'b0);
    check("add_wdata", last_wdata, 64'd8);
    check("add_wmask", last_wmask, 8'hFF);
    check("add_mem", mrd(40'h1000), 64'd8);

    mem[40'h1000] = 64'hFFFF_FFFE_0000_0008;
    op(M_XA_MIN, 40'h1004, SZ_W, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    check("minw_wdata", last_wdata, 64'hFFFF_FFFE_FFFF_FFFE);
    check("minw_wmask", last_wmask, 8'hF0);
    check("minw_mem", mrd(40'h1000), 64'hFFFF_FFFE_0000_0008);
    op(M_XA_MAXU, 40'h1000, SZ_W, 64'hFFFF_FFF0, 64'd8, 1'b0);
    check("maxuw_wmask", last_wmask, 8'h0F);
    check("maxuw_mem", mrd(40'h1000), 64'hFFFF_FFFE_FFFF_FFF0);
    op(M_XA_MAX, 40'h1000, SZ_W, 64'd5, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    check("maxw_mem", mrd(40'h1000), 64'hFFFF_FFFE_0000_0005);
    mem[40'h1008] = 64'hF0F0;
    op(M_XA_XOR, 40'h1008, SZ_D, 64'hFF00, 64'hF0F0, 1'b0);
    check("xor_mem", mrd(40'h1008), 64'h0FF0);

    mem[40'h2000] = 64'h1234;
    op(M_XLR, 40'h2000, SZ_D, 64'd0, 64'h1234, 1'b0);
    repeat (10) @(negedge clk);
    w0 = writes;
    op(M_XSC, 40'h2000, SZ_D, 64'hABCD, 64'd0, 1'b0);
    check("sc_ok_writes", writes - w0, 1);
    check("sc_ok_mem", mrd(40'h2000), 64'hABCD);
    r0 = reads; w0 = writes;
    op(M_XSC, 40'h2000, SZ_D, 64'h5555, 64'd1, 1'b0);
    check("sc_again_mem_ops", (reads - r0) + (writes - w0), 0);

    op(M_XLR, 40'h2000, SZ_D, 64'd0, 64'hABCD, 1'b0);
    probe_at = 40'h2020; probe_kind = 1; probe_seq++;
    repeat (3) @(negedge clk);
    op(M_XSC, 40'h2000, SZ_D, 64'h1, 64'd1, 1'b0);

    op(M_XLR, 40'h2000, SZ_D, 64'd0, 64'hABCD, 1'b0);
    repeat (81) @(negedge clk);
    w0 = writes;
    op(M_XSC, 40'h2000, SZ_D, 64'h1, 64'd1, 1'b0);
    check("sc_timeout_writes", writes - w0, 0);

    probe_at = 40'h2008; probe_kind = 2; probe_seq++;
    op(M_XLR, 40'h2000, SZ_D, 64'd0, 64'hABCD, 1'b0);
    op(M_XSC, 40'h2000, SZ_D, 64'h1, 64'd1, 1'b0);

    op(M_XLR, 40'h3000, SZ_D, 64'd0, 64'd0, 1'b0);
    op(M_XA_ADD, 40'h3008, SZ_D, 64'd1, 64'd0, 1'b0);
    op(M_XSC, 40'h3000, SZ_D, 64'h7, 64'd1, 1'b0);
    check("amo_clr_mem", mrd(40'h3000), 64'd0);

    r0 = reads; w0 = writes;
    sb.push_back('{data: 64'd0, err: 1'b1, tag: tg});
    send(M_XA_SWAP, 40'h1004, SZ_D, 64'h9);
    check("misalign_resp_latency", resp_valid, 1);
    check("misalign_no_mem", mem_req_valid, 0);
    wait_done();
    sb.push_back('{data: 64'd0, err: 1'b1, tag: tg});
    send(M_XRD, 40'h1000, SZ_D, 64'h9);
    check("xrd_resp_latency", resp_valid, 1);
    wait_done();
    op(M_XA_ADD, 40'h1000, 2'd1, 64'h9, 64'd0, 1'b1);
    check("illegal_mem_ops", (reads - r0) + (writes - w0), 0);
    check("illegal_mem_intact", mrd(40'h1000), 64'hFFFF_FFFE_0000_0005);

    mem[40'h4000] = 64'd10;
    stall_w = 5; resp_hold = 3;
    w0 = writes;
    op(M_XA_ADD, 40'h4000, SZ_D, 64'd7, 64'd10, 1'b0);
    stall_w = 0; resp_hold = 0;
    check("stall_one_write", writes - w0, 1);
    check("stall_mem", mrd(40'h4000), 64'd17);

    rd_lat = 20;
    r0 = reads; w0 = writes;
    send(M_XA_ADD, 40'h4000, SZ_D, 64'd1);
    n = 0;
    while (reads == r0 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_ready", req_ready, 1);
    check("rst_mid_resp_valid", resp_valid, 0);
    check("rst_mid_mem_valid", mem_req_valid, 0);
    check("rst_mid_mem_we", mem_req_we, 0);
    check("rst_mid_mem_addr", mem_req_addr, 0);
    check("rst_mid_wdata", mem_req_wdata, 0);
    check("rst_mid_wmask", mem_req_wmask, 0);
    check("rst_mid_resp_data", resp_data, 0);
    check("rst_mid_resp_tag", resp_tag, 0);
    check("rst_mid_resp_err", resp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_lat = 1;
    repeat (25) @(negedge clk);
    check("rst_abandon_no_write", writes - w0, 0);
    op(M_XLR, 40'h4000, SZ_D, 64'd0, 64'd17, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
